uart_rx_fifo: RTL

Receive-side byte buffer that sits directly downstream of the UART receiver. It captures each good received byte (single-cycle `in_valid` pulse, no back-pressure) into a first-word-fall-through FIFO and presents it to the consumer over a valid/ready handshake. It flags overflow with a sticky bit. Optionally, it keeps saturating counts of parity and stop-bit errors reported by the receiver.

---
 rtl/uart_rx_fifo.sv | 116 +++++++++++
 1 files changed

// File: rtl/uart_rx_fifo.sv
// Receive-side FWFT byte FIFO behind the UART receiver, with a sticky overflow flag.
// Define UART_RX_FIFO_ERR_CNT_EN to build saturating parity/stop-error counters.
module uart_rx_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int CNT_W  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DATA_W-1:0]        in_data,
    input  logic                     in_par_err,
    input  logic                     in_stop_err,
    output logic                     out_valid,
    output logic [DATA_W-1:0]        out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    input  logic                     clr_overflow,
    output logic [CNT_W-1:0]         par_err_cnt,
    output logic [CNT_W-1:0]         stop_err_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;
    logic              r_full;
    logic              r_overflow;

    logic              w_pop;
    logic              w_accept;
    logic              w_drop;
    logic [CW-1:0]     w_count_nxt;

    // A push into a full FIFO still fits when the head leaves on the same edge.
    assign w_pop    = (r_count != '0) && out_ready;
    assign w_accept = in_valid && (!r_full || w_pop);
    assign w_drop   = in_valid && r_full && !w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_accept && !w_pop)
            w_count_nxt = r_count + CW'(1);
        else if (w_pop && !w_accept)
            w_count_nxt = r_count - CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_full     <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_accept)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_pop)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= w_count_nxt;
            r_full  <= (w_count_nxt == FULL_CNT);
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_overflow)
                r_overflow <= 1'b0;
        end
    end

    // Storage carries no reset; entries are unreachable while count is 0.
    always_ff @(posedge clk) begin
        if (w_accept && !rst)
            r_mem[r_wr_ptr] <= in_data;
    end

    assign out_valid = (r_count != '0);
    assign out_data  = out_valid ? r_mem[r_rd_ptr] : '0;
    assign count     = r_count;
    assign full      = r_full;
    assign overflow  = r_overflow;

`ifdef UART_RX_FIFO_ERR_CNT_EN
    logic [CNT_W-1:0] r_par_cnt;
    logic [CNT_W-1:0] r_stop_cnt;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            r_par_cnt  <= '0;
            r_stop_cnt <= '0;
        end else begin
            if (in_par_err)
                r_par_cnt <= sat_inc(r_par_cnt);
            if (in_stop_err)
                r_stop_cnt <= sat_inc(r_stop_cnt);
        end
    end

    assign par_err_cnt  = r_par_cnt;
    assign stop_err_cnt = r_stop_cnt;
`else
    logic w_unused_err;
    assign w_unused_err = in_par_err ^ in_stop_err;
    assign par_err_cnt  = '0;
    assign stop_err_cnt = '0;
`endif

endmodule
